// File: rtl/rt8_pkg.sv
// Shared constants and a reference model for the rt8 final adder stage.
package rt8_pkg;

  localparam int unsigned W_DEF  = 16;
  localparam int unsigned CW_DEF = 16;
  localparam int unsigned HALF   = W_DEF / 2;

  // Exact value the final adder must produce for one row set.
  function automatic logic [W_DEF+1:0] rt8_final_ref(
    input logic [W_DEF-1:0] sum,
    input logic [W_DEF-1:0] carry,
    input logic [W_DEF-1:0] err,
    input logic             comp
  );
    logic [W_DEF+1:0] r;
    r = {2'b00, sum} + {1'b0, carry, 1'b0};
    if (comp) r = r + {2'b00, err};
    return r;
  endfunction

endpackage

// File: rtl/rt8_final_adder_if.sv
// Input row-set handshake and result handshake of the rt8 final adder.
interface rt8_final_adder_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_row;
  logic [W-1:0] carry_row;
  logic [W-1:0] err_vec;
  logic         comp_en;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] result;
  logic         out_err;

  modport master (
    output in_valid, sum_row, carry_row, err_vec, comp_en, out_ready,
    input  in_ready, out_valid, result, out_err
  );

  modport slave (
    input  in_valid, sum_row, carry_row, err_vec, comp_en, out_ready,
    output in_ready, out_valid, result, out_err
  );
endinterface

// File: rtl/rt8_csa_row.sv
// Row-wide 3:2 carry-save compressor: a + b + c == s + 2*cy.
module rt8_csa_row #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o
);
  // Per-column full adder.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end
endmodule

// File: rtl/rt8_final_adder.sv
// Two-stage carry-propagate final adder for the rt8 compressor tree with
// optional apx-error compensation and a saturating error-event counter.
module rt8_final_adder
  import rt8_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rt8_final_adder_if.slave     bus,
  input  logic                 clr_cnt,
  output logic [CW-1:0]        err_cnt
);
  localparam int unsigned H  = W / 2;
  localparam int unsigned HI = W + 2 - H;

  logic          s1_valid_q, s1_valid_d;
  logic [H-1:0]  s1_lo_q, s1_lo_d;
  logic          s1_c_q, s1_c_d;
  logic [HI-1:0] s1_hx_q, s1_hx_d, s1_hy_q, s1_hy_d;
  logic          s1_err_q, s1_err_d;
  logic          out_valid_q, out_valid_d;
  logic [W+1:0]  result_q, result_d;
  logic          out_err_q, out_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          s2_ready, in_ready, accept, qualify;
  logic [W:0]    csa_b, csa_c, csa_s, csa_cy;
  logic [W+1:0]  vx, vy;
  logic [H:0]    lo_sum;
  logic [HI-1:0] hi_sum;

  assign s2_ready = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = bus.in_valid && in_ready;
  assign qualify  = accept && (|bus.err_vec);

  assign csa_b = {bus.carry_row, 1'b0};
  assign csa_c = bus.comp_en ? {1'b0, bus.err_vec} : '0;

  rt8_csa_row #(.N(W + 1)) u_csa (
    .a_i ({1'b0, bus.sum_row}),
    .b_i (csa_b),
    .c_i (csa_c),
    .s_o (csa_s),
    .c_o (csa_cy)
  );

  assign vx     = {1'b0, csa_s};
  assign vy     = {csa_cy, 1'b0};
  assign lo_sum = {1'b0, vx[H-1:0]} + {1'b0, vy[H-1:0]};
  assign hi_sum = s1_hx_q + s1_hy_q + {{(HI-1){1'b0}}, s1_c_q};

  // Next-state for both pipeline stages and the error counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_c_d      = s1_c_q;
    s1_hx_d     = s1_hx_q;
    s1_hy_d     = s1_hy_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_err_d   = out_err_q;
    cnt_d       = cnt_q;

    if (in_ready) s1_valid_d = bus.in_valid;
    if (accept) begin
      s1_lo_d  = lo_sum[H-1:0];
      s1_c_d   = lo_sum[H];
      s1_hx_d  = vx[W+1:H];
      s1_hy_d  = vy[W+1:H];
      s1_err_d = |bus.err_vec;
    end

    // Result holds across bubbles and stalls; only a real item overwrites it.
    if (s2_ready) out_valid_d = s1_valid_q;
    if (s1_valid_q && s2_ready) begin
      result_d  = {hi_sum, s1_lo_q};
      out_err_d = s1_err_q;
    end

    if (clr_cnt)
      cnt_d = qualify ? {{(CW-1){1'b0}}, 1'b1} : '0;
    else if (qualify && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Pipeline and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_hx_q     <= '0;
      s1_hy_q     <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_hx_q     <= s1_hx_d;
      s1_hy_q     <= s1_hy_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  generate
    if (W == W_DEF) begin : g_ref_chk
      // Compressed vectors must sum to the exact reference value on every accept.
      always_ff @(posedge clk) begin
        if (rst_n && accept)
          assert (vx + vy == rt8_final_ref(bus.sum_row, bus.carry_row, bus.err_vec, bus.comp_en));
      end
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_err   = out_err_q;
  assign err_cnt       = cnt_q;
endmodule

// File: tb/tb_rt8_final_adder.sv
// Directed/random self-checking bench for rt8_final_adder (W=16, CW=4).
module tb_rt8_final_adder;
  import rt8_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clr_cnt;
  logic [3:0] err_cnt;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         model_cnt = 0;
  logic [17:0] got[$];
  int          gotc[$];
  logic [17:0] expq[$];
  logic [15:0] s, c, e;

  rt8_final_adder_if #(.W(16)) bus ();

  rt8_final_adder #(.W(16), .CW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.result);
      gotc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] sv, input logic [15:0] cv, input logic [15:0] ev, input logic cm);
    bus.in_valid  = 1'b1;
    bus.sum_row   = sv;
    bus.carry_row = cv;
    bus.err_vec   = ev;
    bus.comp_en   = cm;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    bus.sum_row = '0;
    bus.carry_row = '0;
    bus.err_vec = '0;
    bus.comp_en = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // All-ones, compensated
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("ones_c1_lat1", 32'(bus.out_valid), 32'd0);
    step();
    chk("ones_c1_valid", 32'(bus.out_valid), 32'd1);
    chk("ones_c1_result", 32'(bus.result), 32'h3FFFC);
    chk("ones_c1_err", 32'(bus.out_err), 32'd1);
    chk("ones_c1_cnt", 32'(err_cnt), 32'd1);

    // All-ones, uncompensated
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("ones_c0_result", 32'(bus.result), 32'h2FFFD);
    chk("ones_c0_err", 32'(bus.out_err), 32'd1);
    chk("ones_c0_cnt", 32'(err_cnt), 32'd2);

    // Single LSB, latency and bubble hold
    drive(16'h0001, 16'h0000, 16'h0000, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("lsb_lat1", 32'(bus.out_valid), 32'd0);
    step();
    chk("lsb_valid", 32'(bus.out_valid), 32'd1);
    chk("lsb_result", 32'(bus.result), 32'h00001);
    chk("lsb_err", 32'(bus.out_err), 32'd0);
    chk("lsb_cnt", 32'(err_cnt), 32'd2);
    step();
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);
    chk("bubble_hold", 32'(bus.result), 32'h00001);
    model_cnt = 2;

    // 100 back-to-back random items
    got.delete();
    gotc.delete();
    expq.delete();
    for (int i = 0; i < 100; i++) begin
      s = 16'($urandom);
      c = 16'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      drive(s, c, e, 1'($urandom));
      chk("rand_in_ready", 32'(bus.in_ready), 32'd1);
      expq.push_back(rt8_final_ref(s, c, e, bus.comp_en));
      if (e != 0 && model_cnt < 15) model_cnt++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("rand_count", 32'(got.size()), 32'd100);
    if (got.size() == 100) begin
      for (int i = 0; i < 100; i++) begin
        chk("rand_result", 32'(got[i]), 32'(expq[i]));
        chk("rand_no_gap", 32'(gotc[i]), 32'(gotc[0] + i));
      end
    end
    chk("rand_cnt", 32'(err_cnt), 32'(model_cnt));

    // Counter clear, saturation, clear with accept
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_alone", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(16'($urandom), 16'($urandom), 16'(i + 1), 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("cnt_saturate", 32'(err_cnt), 32'd15);
    drive(16'h0003, 16'h0000, 16'h0001, 1'b1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_with_accept", 32'(err_cnt), 32'd1);
    repeat (3) step();

    // Backpressure: 3 items, downstream stalled 5 cycles
    got.delete();
    gotc.delete();
    bus.out_ready = 1'b0;
    drive(16'h1234, 16'h0101, 16'h0000, 1'b0);
    chk("stall_rdy_a", 32'(bus.in_ready), 32'd1);
    step();
    drive(16'h00FF, 16'h8000, 16'h0000, 1'b1);
    chk("stall_rdy_b", 32'(bus.in_ready), 32'd1);
    step();
    drive(16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdy_low", 32'(bus.in_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_hold", 32'(bus.result), 32'h01436);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("stall_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("stall_order0", 32'(got[0]), 32'h01436);
      chk("stall_order1", 32'(got[1]), 32'h100FF);
      chk("stall_order2", 32'(got[2]), 32'h10001);
    end
    chk("stall_cnt", 32'(err_cnt), 32'd1);

    // Reset with two items in flight
    drive(16'h0F0F, 16'h0F0F, 16'h0001, 1'b1);
    step();
    drive(16'h7777, 16'h1111, 16'h0002, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    step();
    step();
    got.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    chk("post_rst_count", 32'(got.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
